sim_commit_monitor: RTL and testbench

Parametrised simulation-side commit monitor for the NPC core. It watches up to NR_COMMIT writeback/commit channels per cycle and detects program termination: ebreak, unknown instruction, or a no-commit watchdog timeout. It keeps instruction and cycle counters and latches a halt reason, halt code (a0) and halt PC. After a drain window it raises done, which the sim top uses to issue the DPI ebreak/unknown_inst calls and $finish.

---
 rtl/sim_pkg.sv | 19 +
 rtl/sim_commit_monitor_if.sv | 19 +
 rtl/sim_watchdog.sv | 31 +++
 rtl/sim_commit_monitor.sv | 150 +++++++++++++++
 tb/tb_sim_commit_monitor.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/sim_pkg.sv
// Shared types and constants for the simulation commit monitor.
package sim_pkg;

    typedef enum logic [1:0] {
        HALT_NONE    = 2'd0,
        HALT_EBREAK  = 2'd1,
        HALT_UNKNOWN = 2'd2,
        HALT_TIMEOUT = 2'd3
    } halt_reason_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } mon_state_e;

    localparam logic [31:0] EBREAK_INST_DEFAULT = 32'h0010_0073;

endpackage

// File: rtl/sim_commit_monitor_if.sv
// Commit/writeback channel bundle observed by the commit monitor.
interface sim_commit_monitor_if #(
    parameter int unsigned NR_COMMIT = 1,
    parameter int unsigned XLEN      = 64
);
    logic [NR_COMMIT-1:0]      commit_valid;
    logic [NR_COMMIT*XLEN-1:0] commit_pc;
    logic [NR_COMMIT*32-1:0]   commit_inst;
    logic                      unknown_inst_flag;
    logic [XLEN-1:0]           gpr_a0;

    modport master (
        output commit_valid, commit_pc, commit_inst, unknown_inst_flag, gpr_a0
    );

    modport slave (
        input commit_valid, commit_pc, commit_inst, unknown_inst_flag, gpr_a0
    );
endinterface

// File: rtl/sim_watchdog.sv
// No-commit watchdog: counts enabled cycles without a clear, pulses expire on the last one.
module sim_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = clr_i ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/sim_commit_monitor.sv
// Commit monitor: counts retired instructions and cycles, detects ebreak / unknown / timeout
// termination, latches halt information and raises done after a drain window.
module sim_commit_monitor
    import sim_pkg::*;
#(
    parameter int unsigned NR_COMMIT      = 1,
    parameter int unsigned XLEN           = 64,
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned DRAIN_CYCLES   = 4,
    parameter logic [31:0] EBREAK_INST    = EBREAK_INST_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    sim_commit_monitor_if.slave   cif,
    output logic                  halt,
    output logic                  done,
    output logic [1:0]            halt_reason,
    output logic [XLEN-1:0]       halt_code,
    output logic [XLEN-1:0]       halt_pc,
    output logic [63:0]           inst_count,
    output logic [63:0]           cycle_count
);
    localparam int unsigned PW = $clog2(NR_COMMIT + 1);
    localparam int unsigned DW = $clog2(DRAIN_CYCLES + 2);

    mon_state_e       state_q, state_d;
    halt_reason_e     reason_q, reason_d, event_reason;
    logic [XLEN-1:0]  last_pc_q, last_pc_d;
    logic [XLEN-1:0]  code_q, code_d;
    logic [XLEN-1:0]  hpc_q, hpc_d;
    logic [63:0]      ic_q, ic_d;
    logic [63:0]      cc_q, cc_d;
    logic [DW-1:0]    drain_q, drain_d;

    logic [PW-1:0]    n_commit;
    logic [XLEN-1:0]  pc_upd;
    logic             eb_found;
    logic             any_commit;
    logic             in_run;
    logic             wd_expire;

    assign in_run = (state_q == ST_RUN);

    // Channels past the oldest ebreak are dropped; the ebreak is then the youngest counted
    // commit, so the post-update last PC doubles as the ebreak PC.
    always_comb begin
        n_commit = '0;
        eb_found = 1'b0;
        pc_upd   = last_pc_q;
        for (int unsigned k = 0; k < NR_COMMIT; k++) begin
            if (cif.commit_valid[k] && !eb_found) begin
                n_commit = n_commit + 1'b1;
                pc_upd   = cif.commit_pc[k*XLEN +: XLEN];
                if (cif.commit_inst[k*32 +: 32] == EBREAK_INST) begin
                    eb_found = 1'b1;
                end
            end
        end
    end

    assign any_commit = (n_commit != '0);

    sim_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clock),
        .rst_ni   (reset),
        .en_i     (in_run),
        .clr_i    (any_commit),
        .expire_o (wd_expire)
    );

    always_comb begin
        event_reason = HALT_NONE;
        if (cif.unknown_inst_flag) begin
            event_reason = HALT_UNKNOWN;
        end else if (eb_found) begin
            event_reason = HALT_EBREAK;
        end else if (wd_expire) begin
            event_reason = HALT_TIMEOUT;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:    if (event_reason != HALT_NONE) state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_q == DW'(DRAIN_CYCLES)) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        ic_d      = ic_q;
        cc_d      = cc_q;
        last_pc_d = last_pc_q;
        drain_d   = drain_q;
        reason_d  = reason_q;
        code_d    = code_q;
        hpc_d     = hpc_q;
        if (state_q != ST_HALTED) begin
            cc_d = cc_q + 64'd1;
        end
        if (state_q == ST_DRAIN) begin
            drain_d = drain_q + 1'b1;
        end
        if (in_run) begin
            ic_d      = ic_q + 64'(n_commit);
            last_pc_d = pc_upd;
            if (event_reason != HALT_NONE) begin
                reason_d = event_reason;
                code_d   = (event_reason == HALT_EBREAK) ? cif.gpr_a0 : '0;
                hpc_d    = pc_upd;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            reason_q  <= HALT_NONE;
            last_pc_q <= '0;
            code_q    <= '0;
            hpc_q     <= '0;
            ic_q      <= '0;
            cc_q      <= '0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            reason_q  <= reason_d;
            last_pc_q <= last_pc_d;
            code_q    <= code_d;
            hpc_q     <= hpc_d;
            ic_q      <= ic_d;
            cc_q      <= cc_d;
            drain_q   <= drain_d;
        end
    end

    always_comb begin
        halt        = (state_q != ST_RUN);
        done        = (state_q == ST_HALTED);
        halt_reason = reason_q;
        halt_code   = code_q;
        halt_pc     = hpc_q;
        inst_count  = ic_q;
        cycle_count = cc_q;
    end
endmodule

// File: tb/tb_sim_commit_monitor.sv
// Bench for sim_commit_monitor: a 2-channel instance (timeout 8, drain 0) and a 1-channel
// instance (default timeout, drain 4), driven from vector tables through a scoreboard queue.
module tb_sim_commit_monitor;

    localparam logic [31:0] EBRK = 32'h0010_0073;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef struct {
        logic [1:0]  v;
        logic [63:0] pc0;
        logic [31:0] i0;
        logic [63:0] pc1;
        logic [31:0] i1;
        logic        unk;
        logic [63:0] a0;
        logic [63:0] e_ic;
        logic        e_halt;
        logic        e_done;
        logic [1:0]  e_reason;
        logic [63:0] e_code;
        logic [63:0] e_pc;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    vec_t sbq[$];
    vec_t tbl[$];

    sim_commit_monitor_if #(.NR_COMMIT(2), .XLEN(64)) ifa ();
    sim_commit_monitor_if #(.NR_COMMIT(1), .XLEN(64)) ifb ();

    logic        a_halt, a_done, b_halt, b_done;
    logic [1:0]  a_reason, b_reason;
    logic [63:0] a_code, a_pc, a_ic, a_cc, b_code, b_pc, b_ic, b_cc;

    sim_commit_monitor #(
        .NR_COMMIT(2), .XLEN(64), .TIMEOUT_CYCLES(8), .DRAIN_CYCLES(0)
    ) u_a (
        .clock(clk), .reset(rst_a), .cif(ifa),
        .halt(a_halt), .done(a_done), .halt_reason(a_reason), .halt_code(a_code),
        .halt_pc(a_pc), .inst_count(a_ic), .cycle_count(a_cc)
    );

    sim_commit_monitor #(
        .NR_COMMIT(1), .XLEN(64), .DRAIN_CYCLES(4)
    ) u_b (
        .clock(clk), .reset(rst_b), .cif(ifb),
        .halt(b_halt), .done(b_done), .halt_reason(b_reason), .halt_code(b_code),
        .halt_pc(b_pc), .inst_count(b_ic), .cycle_count(b_cc)
    );

    function automatic vec_t row(input logic [1:0] v, input logic [63:0] pc0, input logic [31:0] i0,
                                 input logic [63:0] pc1, input logic [31:0] i1, input logic unk,
                                 input logic [63:0] a0, input logic [63:0] e_ic, input logic e_halt,
                                 input logic e_done, input logic [1:0] e_reason,
                                 input logic [63:0] e_code, input logic [63:0] e_pc);
        vec_t r;
        r.v = v; r.pc0 = pc0; r.i0 = i0; r.pc1 = pc1; r.i1 = i1; r.unk = unk; r.a0 = a0;
        r.e_ic = e_ic; r.e_halt = e_halt; r.e_done = e_done; r.e_reason = e_reason;
        r.e_code = e_code; r.e_pc = e_pc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic get_out(input int d, output logic h, output logic dn, output logic [1:0] rs,
                           output logic [63:0] cd, output logic [63:0] pc,
                           output logic [63:0] ic, output logic [63:0] cc);
        if (d == 0) begin
            h = a_halt; dn = a_done; rs = a_reason; cd = a_code; pc = a_pc; ic = a_ic; cc = a_cc;
        end else begin
            h = b_halt; dn = b_done; rs = b_reason; cd = b_code; pc = b_pc; ic = b_ic; cc = b_cc;
        end
    endtask

    task automatic drive(input int d, input vec_t r);
        if (d == 0) begin
            ifa.commit_valid      = r.v;
            ifa.commit_pc         = {r.pc1, r.pc0};
            ifa.commit_inst       = {r.i1, r.i0};
            ifa.unknown_inst_flag = r.unk;
            ifa.gpr_a0            = r.a0;
        end else begin
            ifb.commit_valid      = r.v[0];
            ifb.commit_pc         = r.pc0;
            ifb.commit_inst       = r.i0;
            ifb.unknown_inst_flag = r.unk;
            ifb.gpr_a0            = r.a0;
        end
    endtask

    task automatic sample_check(input int d, input string tag, input int idx);
        vec_t e;
        logic h, dn;
        logic [1:0] rs;
        logic [63:0] cd, pc, ic, cc;
        if (sbq.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s[%0d] scoreboard empty: got none required one entry", tag, idx);
            return;
        end
        e = sbq.pop_front();
        get_out(d, h, dn, rs, cd, pc, ic, cc);
        chk($sformatf("%s[%0d].inst_count", tag, idx), ic, e.e_ic);
        chk($sformatf("%s[%0d].halt", tag, idx), 64'(h), 64'(e.e_halt));
        chk($sformatf("%s[%0d].done", tag, idx), 64'(dn), 64'(e.e_done));
        chk($sformatf("%s[%0d].halt_reason", tag, idx), 64'(rs), 64'(e.e_reason));
        chk($sformatf("%s[%0d].halt_code", tag, idx), cd, e.e_code);
        chk($sformatf("%s[%0d].halt_pc", tag, idx), pc, e.e_pc);
    endtask

    task automatic run_tbl(input int d, input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(d, tbl[i]);
            sbq.push_back(tbl[i]);
            @(posedge clk);
            #1;
            sample_check(d, tag, i);
        end
        tbl.delete();
    endtask

    // Reset is asserted mid-cycle so the zero check also proves it acts asynchronously.
    task automatic do_reset(input int d, input string tag);
        logic h, dn;
        logic [1:0] rs;
        logic [63:0] cd, pc, ic, cc;
        if (d == 0) rst_a = 1'b0; else rst_b = 1'b0;
        #1;
        get_out(d, h, dn, rs, cd, pc, ic, cc);
        chk({tag, ".rst.halt"}, 64'(h), 64'd0);
        chk({tag, ".rst.done"}, 64'(dn), 64'd0);
        chk({tag, ".rst.reason"}, 64'(rs), 64'd0);
        chk({tag, ".rst.code"}, cd, 64'd0);
        chk({tag, ".rst.pc"}, pc, 64'd0);
        chk({tag, ".rst.inst_count"}, ic, 64'd0);
        chk({tag, ".rst.cycle_count"}, cc, 64'd0);
        drive(d, row(2'b00, '0, '0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 2'd0, '0, '0));
        @(posedge clk);
        #1;
        if (d == 0) rst_a = 1'b1; else rst_b = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish required finish before 1ms");
        $fatal(1, "bench timed out");
    end

    initial begin
        drive(0, row(2'b00, '0, '0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 2'd0, '0, '0));
        drive(1, row(2'b00, '0, '0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 2'd0, '0, '0));
        @(posedge clk);
        #1;

        // 1-channel: 10 commits then ebreak, ignored junk during drain, done 5 cycles after halt
        do_reset(1, "B1");
        for (int i = 0; i < 10; i++)
            tbl.push_back(row(2'b01, 64'h8000_0000 + 64'(4 * i), NOP, 'x, 'x, 1'b0, 64'd0,
                              64'(i + 1), 1'b0, 1'b0, 2'd0, 64'd0, 64'd0));
        tbl.push_back(row(2'b01, 64'h8000_0028, EBRK, 'x, 'x, 1'b0, 64'd0,
                          64'd11, 1'b1, 1'b0, 2'd1, 64'd0, 64'h8000_0028));
        for (int k = 1; k <= 7; k++)
            tbl.push_back(row(2'b01, 64'h1234, EBRK, 'x, 'x, 1'b1, 64'hdead,
                              64'd11, 1'b1, (k >= 5), 2'd1, 64'd0, 64'h8000_0028));
        run_tbl(1, "B1");
        chk("B1.cycle_count_frozen", b_cc, 64'd16);

        // 1-channel: reset asserted while in DRAIN, then counting restarts from zero
        do_reset(1, "B2a");
        tbl.push_back(row(2'b01, 64'h100, NOP, 'x, 'x, 1'b0, 64'd5, 64'd1, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0));
        tbl.push_back(row(2'b01, 64'h104, EBRK, 'x, 'x, 1'b0, 64'd5, 64'd2, 1'b1, 1'b0, 2'd1, 64'd5, 64'h104));
        tbl.push_back(row(2'b00, 'x, 'x, 'x, 'x, 1'b0, 64'd5, 64'd2, 1'b1, 1'b0, 2'd1, 64'd5, 64'h104));
        run_tbl(1, "B2");
        do_reset(1, "B2b");
        tbl.push_back(row(2'b01, 64'h200, NOP, 'x, 'x, 1'b0, 64'd0, 64'd1, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0));
        run_tbl(1, "B2c");
        chk("B2c.cycle_count", b_cc, 64'd1);

        // 2-channel: mixed valid patterns, then ebreak on ch0 hides a valid ch1
        do_reset(0, "A1");
        tbl.push_back(row(2'b11, 64'h100, NOP, 64'h104, NOP, 1'b0, 64'd0, 64'd2, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0));
        tbl.push_back(row(2'b10, 'x, 'x, 64'h108, NOP, 1'b0, 64'd0, 64'd3, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0));
        tbl.push_back(row(2'b01, 64'h10c, NOP, 'x, 'x, 1'b0, 64'd0, 64'd4, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0));
        tbl.push_back(row(2'b00, 'x, EBRK, 'x, EBRK, 1'b0, 64'd0, 64'd4, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0));
        tbl.push_back(row(2'b11, 64'h110, EBRK, 64'h114, NOP, 1'b0, 64'h2A, 64'd5, 1'b1, 1'b0, 2'd1, 64'h2A, 64'h110));
        tbl.push_back(row(2'b11, 64'h120, NOP, 64'h124, NOP, 1'b1, 64'h99, 64'd5, 1'b1, 1'b1, 2'd1, 64'h2A, 64'h110));
        tbl.push_back(row(2'b00, 'x, 'x, 'x, 'x, 1'b0, 64'h99, 64'd5, 1'b1, 1'b1, 2'd1, 64'h2A, 64'h110));
        run_tbl(0, "A1");

        // 2-channel: unknown instruction outranks an ebreak on ch1 in the same cycle
        do_reset(0, "A2");
        tbl.push_back(row(2'b01, 64'h200, NOP, 'x, 'x, 1'b0, 64'h55, 64'd1, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0));
        tbl.push_back(row(2'b11, 64'h204, NOP, 64'h208, EBRK, 1'b1, 64'h55, 64'd3, 1'b1, 1'b0, 2'd2, 64'd0, 64'h208));
        tbl.push_back(row(2'b00, 'x, 'x, 'x, 'x, 1'b0, 64'h55, 64'd3, 1'b1, 1'b1, 2'd2, 64'd0, 64'h208));
        run_tbl(0, "A2");

        // Timeout: halt on the 8th idle cycle after the last commit
        do_reset(0, "A3");
        tbl.push_back(row(2'b01, 64'h8000_0100, NOP, 'x, 'x, 1'b0, 64'h77, 64'd1, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0));
        for (int k = 1; k <= 7; k++)
            tbl.push_back(row(2'b00, 'x, 'x, 'x, 'x, 1'b0, 64'h77, 64'd1, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0));
        tbl.push_back(row(2'b00, 'x, 'x, 'x, 'x, 1'b0, 64'h77, 64'd1, 1'b1, 1'b0, 2'd3, 64'd0, 64'h8000_0100));
        tbl.push_back(row(2'b00, 'x, 'x, 'x, 'x, 1'b0, 64'h77, 64'd1, 1'b1, 1'b1, 2'd3, 64'd0, 64'h8000_0100));
        run_tbl(0, "A3");

        // Commit landing on the would-be expiry cycle restarts the idle window
        do_reset(0, "A4");
        tbl.push_back(row(2'b01, 64'h8000_0200, NOP, 'x, 'x, 1'b0, 64'd0, 64'd1, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0));
        for (int k = 1; k <= 7; k++)
            tbl.push_back(row(2'b00, 'x, 'x, 'x, 'x, 1'b0, 64'd0, 64'd1, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0));
        tbl.push_back(row(2'b10, 'x, 'x, 64'h8000_0204, NOP, 1'b0, 64'd0, 64'd2, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0));
        for (int k = 1; k <= 7; k++)
            tbl.push_back(row(2'b00, 'x, 'x, 'x, 'x, 1'b0, 64'd0, 64'd2, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0));
        tbl.push_back(row(2'b00, 'x, 'x, 'x, 'x, 1'b0, 64'd0, 64'd2, 1'b1, 1'b0, 2'd3, 64'd0, 64'h8000_0204));
        run_tbl(0, "A4");
        chk("A4.cycle_count", a_cc, 64'd17);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
